// File: rtl/bcd_serial_converter_if.sv
// Handshake and data bundle between the reaction timer and the BCD converter.
// The master side requests conversions; the slave side is the converter.
interface bcd_serial_converter_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (
        output start, bin,
        input  busy, done, bcd, overflow
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, overflow
    );
endinterface

// File: rtl/bcd_serial_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// One add-3 correction cell per digit is reused across all iterations.
// Results are published only in the DONE cycle, so the display never
// sees partially converted digits.
module bcd_serial_converter #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bcd_serial_converter_if.slave   bus
);
    localparam int          CW      = $clog2(BIN_W + 1);
    localparam int          BCD_W   = 4 * DIGITS;
    localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [BIN_W-1:0]   bin_sr;
    logic [BCD_W-1:0]   scratch;
    logic [CW-1:0]      count;
    logic               ovf_pend;
    logic               busy;
    logic               done;
    logic [BCD_W-1:0]   bcd;
    logic               overflow;

    logic [BCD_W-1:0]   scratch_corr;
    logic [BCD_W-1:0]   scratch_next;
    logic [BIN_W-1:0]   bin_next;
    logic [31:0]        bin_ext;

    // Digits 13..15 cannot occur from valid shifting; they collapse to 0.
    function automatic logic [3:0] add3(input logic [3:0] d);
        if (d <= 4'd4)
            return d;
        else if (d <= 4'd12)
            return d + 4'd3;
        else
            return 4'd0;
    endfunction

    assign bin_ext = 32'(bus.bin);

    // One double-dabble step: correct every digit, then shift the binary MSB in.
    always_comb begin
        scratch_corr = '0;
        for (int i = 0; i < DIGITS; i++) begin
            scratch_corr[i*4 +: 4] = add3(scratch[i*4 +: 4]);
        end
        scratch_next = {scratch_corr[BCD_W-2:0], bin_sr[BIN_W-1]};
        bin_next     = {bin_sr[BIN_W-2:0], 1'b0};
    end

    // Control FSM with registered handshake outputs and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bin_sr   <= '0;
            scratch  <= '0;
            count    <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state    <= SHIFT;
                        busy     <= 1'b1;
                        bin_sr   <= bus.bin;
                        scratch  <= '0;
                        count    <= CW'(BIN_W);
                        ovf_pend <= (bin_ext > MAX_VAL);
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_next;
                    bin_sr  <= bin_next;
                    count   <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        bcd      <= ovf_pend ? {DIGITS{4'h9}} : scratch_next;
                        overflow <= ovf_pend;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.bcd      = bcd;
    assign bus.overflow = overflow;
endmodule

// File: tb/tb_bcd_serial_converter.sv
// Directed bench for bcd_serial_converter: reset values, latency, overflow
// saturation, back-to-back launch, async abort and a strided value sweep.
module tb_bcd_serial_converter;
    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    bcd_serial_converter_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bcd_serial_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
        end
    endtask

    // Decimal reference: digit i is (v / 10^i) % 10, saturating above 9999.
    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int          x;
        if (v > 9999) return 16'h9999;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Launch one conversion with a single-cycle start and check the result.
    task automatic applyStimulus(input int value, input string tag);
        int          cycles;
        int          busy_cycles;
        logic        bcd_moved;
        logic [15:0] prev_bcd;
        logic [15:0] exp_bcd;
        logic        exp_ovf;
        exp_bcd = ref_bcd(value);
        exp_ovf = (value > 9999);
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = BIN_W'(value);
        prev_bcd  = bus.bcd;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.bin     = ~bus.bin;
        cycles      = 1;
        busy_cycles = 0;
        bcd_moved   = 1'b0;
        while (!bus.done && cycles < 40) begin
            if (bus.busy) busy_cycles++;
            if (bus.bcd !== prev_bcd) bcd_moved = 1'b1;
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "_latency"}, cycles, 15);
        checkOutput({tag, "_busy_cycles"}, busy_cycles, 14);
        checkOutput({tag, "_bcd_stable_in_shift"}, 32'(bcd_moved), 0);
        checkOutput({tag, "_bcd"}, 32'(bus.bcd), 32'(exp_bcd));
        checkOutput({tag, "_overflow"}, 32'(bus.overflow), 32'(exp_ovf));
        checkOutput({tag, "_busy_at_done"}, 32'(bus.busy), 0);
        @(negedge clk);
        checkOutput({tag, "_done_width"}, 32'(bus.done), 0);
        checkOutput({tag, "_bcd_held"}, 32'(bus.bcd), 32'(exp_bcd));
    endtask

    // Main sequence of directed scenarios.
    initial begin
        int   cycles;
        logic seen_done;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.bin   = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(bus.busy), 0);
        checkOutput("reset_done", 32'(bus.done), 0);
        checkOutput("reset_bcd", 32'(bus.bcd), 0);
        checkOutput("reset_overflow", 32'(bus.overflow), 0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(0, "zero");
        applyStimulus(1234, "v1234");
        applyStimulus(9999, "v9999");
        applyStimulus(10000, "v10000");
        applyStimulus(16383, "v16383");
        applyStimulus(5, "v5_after_ovf");

        // Start held high through a conversion, bin changed while busy.
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = BIN_W'(42);
        @(negedge clk);
        bus.bin = BIN_W'(77);
        cycles  = 1;
        while (!bus.done && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("b2b_first_latency", cycles, 15);
        checkOutput("b2b_first_bcd", 32'(bus.bcd), 32'h0042);
        @(negedge clk);
        bus.start = 1'b0;
        cycles    = 1;
        checkOutput("b2b_relaunch_busy", 32'(bus.busy), 1);
        repeat (5) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("b2b_bcd_held_in_shift", 32'(bus.bcd), 32'h0042);
        while (!bus.done && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("b2b_second_latency", cycles, 15);
        checkOutput("b2b_second_bcd", 32'(bus.bcd), 32'h0077);
        @(negedge clk);

        // Asynchronous abort in SHIFT cycle 7 of a conversion of 500.
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = BIN_W'(500);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(bus.busy), 0);
        checkOutput("abort_done", 32'(bus.done), 0);
        checkOutput("abort_bcd", 32'(bus.bcd), 0);
        checkOutput("abort_overflow", 32'(bus.overflow), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        seen_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) seen_done = 1'b1;
        end
        checkOutput("abort_no_done", 32'(seen_done), 0);
        checkOutput("abort_bcd_after", 32'(bus.bcd), 0);
        applyStimulus(500, "post_abort");

        // Strided sweep of the valid range against the decimal model.
        for (int v = 0; v <= 9999; v += 97) begin
            applyStimulus(v, "sweep");
        end
        applyStimulus(9998, "sweep_top");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
